qemu_rd_arb: RTL

Round-robin arbiter and sequencer for the single host (QEMU/DPI) read-request channel of the PCIe bridge. NREQ AXI-side read engines present read requests. The block grants one at a time and forwards the granted request to the host port. It then routes the returned data beats to the owning requester. It enforces one outstanding host read, and it completes a hung request with an error response after a programmable timeout.

---
 rtl/qemu_rd_arb.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/qemu_rd_arb.sv
// qemu_rd_arb
// Round-robin arbiter and sequencer for the single host read-request channel.
// NREQ read engines compete for the host port. One request is granted and
// forwarded to the host, and its returned beats are routed back to the owner.
// Only one host read is outstanding at a time. A burst that stalls on the host
// side for TMO cycles is closed with a single SLVERR beat.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_*, o_req_ready      packed per-requester request channel, one-hot accept
//   o_h_*, i_h_ready          host request (latched fields, owner index in o_h_src)
//   i_h_rvalid/rdata, o_h_rready  host read-data channel
//   o_rvalid/rdata/rresp/rlast, i_rready  per-requester read-data channel
//   o_busy                    block is not idle
//   o_stray                   pulse per host beat discarded while idle
module qemu_rd_arb #(
    parameter int NREQ = 2,
    parameter int TAGW = 3,
    parameter int ADRW = 64,
    parameter int DATW = 512,
    parameter int TMOW = 16,
    parameter int TMO  = 1000,
    parameter int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*ADRW-1:0] i_req_addr,
    input  logic [NREQ*8-1:0]    i_req_len,
    input  logic [NREQ*3-1:0]    i_req_size,
    input  logic [NREQ*TAGW-1:0] i_req_id,
    output logic                 o_h_valid,
    input  logic                 i_h_ready,
    output logic [ADRW-1:0]      o_h_addr,
    output logic [7:0]           o_h_len,
    output logic [2:0]           o_h_size,
    output logic [TAGW-1:0]      o_h_id,
    output logic [SRCW-1:0]      o_h_src,
    input  logic                 i_h_rvalid,
    input  logic [DATW-1:0]      i_h_rdata,
    output logic                 o_h_rready,
    output logic [NREQ-1:0]      o_rvalid,
    output logic [DATW-1:0]      o_rdata,
    output logic [1:0]           o_rresp,
    output logic                 o_rlast,
    input  logic [NREQ-1:0]      i_rready,
    output logic                 o_busy,
    output logic                 o_stray
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TMO - 1);
    localparam logic [SRCW-1:0] PTR_RST  = SRCW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    logic [1:0]      state_q, state_d;
    logic [SRCW-1:0] ptr_q,   ptr_d;
    logic [SRCW-1:0] src_q,   src_d;
    logic [ADRW-1:0] addr_q,  addr_d;
    logic [7:0]      len_q,   len_d;
    logic [2:0]      size_q,  size_d;
    logic [TAGW-1:0] id_q,    id_d;
    logic [7:0]      cnt_q,   cnt_d;
    logic [TMOW-1:0] tmr_q,   tmr_d;

    logic [SRCW-1:0] win;
    logic            win_found;
    logic            beat_hs;

    // Rotating priority search starting just after the last winner. Walking
    // the offsets from farthest to nearest lets the nearest valid requester
    // overwrite any earlier candidate.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            if (i_req_valid[SRCW'((int'(ptr_q) + i) % NREQ)]) begin
                win       = SRCW'((int'(ptr_q) + i) % NREQ);
                win_found = 1'b1;
            end
        end
    end

    assign beat_hs = (state_q == ST_DATA) && i_h_rvalid && i_rready[src_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_ISSUE;
                    ptr_d   = win;
                    src_d   = win;
                    addr_d  = i_req_addr[int'(win)*ADRW +: ADRW];
                    len_d   = i_req_len[int'(win)*8 +: 8];
                    size_d  = i_req_size[int'(win)*3 +: 3];
                    id_d    = i_req_id[int'(win)*TAGW +: TAGW];
                    cnt_d   = '0;
                    tmr_d   = '0;
                end
            end
            ST_ISSUE: begin
                if (i_h_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // A beat held back by the requester freezes the timer: only a
                // silent host counts towards the timeout.
                if (beat_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    tmr_d = '0;
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                    end
                end else if (!i_h_rvalid) begin
                    if (tmr_q == TMO_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        tmr_d = tmr_q + TMOW'(1);
                    end
                end
            end
            ST_ERR: begin
                if (i_rready[src_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            src_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
        end
    end

    // The idle state keeps the host data channel drained so that beats from
    // an abandoned burst cannot block the host; they are flagged as stray.
    always_comb begin
        o_req_ready = '0;
        o_h_rready  = 1'b0;
        o_rvalid    = '0;
        o_rdata     = '0;
        o_rresp     = 2'b00;
        o_rlast     = 1'b0;
        o_stray     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_h_rready = 1'b1;
                o_stray    = i_h_rvalid;
                if (win_found) begin
                    o_req_ready = ONE_HOT0 << win;
                end
            end
            ST_DATA: begin
                o_rvalid[src_q] = i_h_rvalid;
                o_rdata         = i_h_rdata;
                o_rlast         = (cnt_q == len_q);
                o_h_rready      = i_rready[src_q];
            end
            ST_ERR: begin
                o_rvalid[src_q] = 1'b1;
                o_rresp         = 2'b10;
                o_rlast         = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_h_valid = (state_q == ST_ISSUE);
    assign o_h_addr  = addr_q;
    assign o_h_len   = len_q;
    assign o_h_size  = size_q;
    assign o_h_id    = id_q;
    assign o_h_src   = src_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule
